// File: rtl/apb4_archinfo_arb_pkg.sv
// Shared types and constants for the round-robin APB4 archinfo master.
package apb4_archinfo_arb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2
   } state_t;

   localparam int unsigned NREQ_DEF    = 4;
   localparam int unsigned AW_DEF      = 6;
   localparam int unsigned TIMEOUT_DEF = 16;

   // Counter only has to reach TIMEOUT-1; keep at least one bit when disabled.
   function automatic int unsigned tmo_cnt_w(input int unsigned tmo);
      return (tmo < 2) ? 1 : $clog2(tmo);
   endfunction

endpackage

// File: rtl/apb4_archinfo_arb_rr_arbiter.sv
// Combinational round-robin grant: first valid index at or above ptr_i, wrapping at NREQ.
module rr_arbiter
   import apb4_archinfo_arb_pkg::*;
#(
   parameter int unsigned NREQ = NREQ_DEF,
   parameter int unsigned IW   = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] valid_i,
   input  logic [IW-1:0]   ptr_i,
   output logic [NREQ-1:0] gnt_o,
   output logic [IW-1:0]   gnt_idx_o,
   output logic            any_o
);

   logic [IW-1:0] j;

   always_comb begin
      gnt_o     = '0;
      gnt_idx_o = '0;
      any_o     = 1'b0;
      j         = '0;
      for (int unsigned k = 0; k < NREQ; k++) begin
         j = IW'((32'(ptr_i) + k) % NREQ);
         if (!any_o && valid_i[j]) begin
            any_o     = 1'b1;
            gnt_o[j]  = 1'b1;
            gnt_idx_o = j;
         end
      end
   end

endmodule

// File: rtl/apb4_archinfo_arb.sv
// Round-robin APB4 master serialising NREQ single-beat requesters onto one archinfo slave,
// with a watchdog that force-completes an ACCESS phase the slave never finishes.
//
// state  | meaning
// IDLE   | arbitrate, accept one command, psel/penable low
// SETUP  | APB setup phase (psel=1, penable=0)
// ACCESS | APB access phase, wait for pready or watchdog expiry
module apb4_archinfo_arb
   import apb4_archinfo_arb_pkg::*;
#(
   parameter int unsigned NREQ    = NREQ_DEF,
   parameter int unsigned AW      = AW_DEF,
   parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
   input  logic               hclk,
   input  logic               hreset,
   input  logic [NREQ-1:0]    req_valid_i,
   output logic [NREQ-1:0]    req_ready_o,
   input  logic [NREQ-1:0]    req_write_i,
   input  logic [NREQ*AW-1:0] req_addr_i,
   input  logic [NREQ*32-1:0] req_wdata_i,
   output logic [NREQ-1:0]    rsp_valid_o,
   output logic [31:0]        rsp_rdata_o,
   output logic               rsp_err_o,
   output logic [AW-1:0]      paddr_o,
   output logic               psel_o,
   output logic               penable_o,
   output logic               pwrite_o,
   output logic [31:0]        pwdata_o,
   input  logic [31:0]        prdata_i,
   input  logic               pready_i,
   input  logic               pslverr_i,
   output logic               busy_o
);

   localparam int unsigned IW = $clog2(NREQ);
   localparam int unsigned CW = tmo_cnt_w(TIMEOUT);
   localparam logic [CW-1:0] TLAST = CW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

   state_t            state_q, state_d;
   logic [IW-1:0]     rr_ptr_q, rr_ptr_d, gidx_q, gidx_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [AW-1:0]     paddr_q, paddr_d;
   logic              pwrite_q, pwrite_d, psel_q, psel_d, penable_q, penable_d;
   logic [31:0]       pwdata_q, pwdata_d, rsp_rdata_q, rsp_rdata_d;
   logic [NREQ-1:0]   rsp_valid_q, rsp_valid_d, ready_d;
   logic              rsp_err_q, rsp_err_d;

   logic [NREQ-1:0]   gnt_oh;
   logic [IW-1:0]     gnt_idx;
   logic              gnt_any, tmo_hit;
   logic [AW-1:0]     addr_sel;

   rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_arb (
      .valid_i   (req_valid_i),
      .ptr_i     (rr_ptr_q),
      .gnt_o     (gnt_oh),
      .gnt_idx_o (gnt_idx),
      .any_o     (gnt_any)
   );

   assign addr_sel = req_addr_i[32'(gnt_idx)*AW +: AW];
   assign tmo_hit  = (TIMEOUT != 0) && (cnt_q == TLAST);

   always_ff @(posedge hclk or posedge hreset) begin
      if (hreset) begin
         state_q     <= IDLE;
         rr_ptr_q    <= '0;
         gidx_q      <= '0;
         cnt_q       <= '0;
         paddr_q     <= '0;
         pwrite_q    <= 1'b0;
         pwdata_q    <= '0;
         psel_q      <= 1'b0;
         penable_q   <= 1'b0;
         rsp_valid_q <= '0;
         rsp_rdata_q <= '0;
         rsp_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         rr_ptr_q    <= rr_ptr_d;
         gidx_q      <= gidx_d;
         cnt_q       <= cnt_d;
         paddr_q     <= paddr_d;
         pwrite_q    <= pwrite_d;
         pwdata_q    <= pwdata_d;
         psel_q      <= psel_d;
         penable_q   <= penable_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_err_q   <= rsp_err_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      rr_ptr_d    = rr_ptr_q;
      gidx_d      = gidx_q;
      cnt_d       = cnt_q;
      paddr_d     = paddr_q;
      pwrite_d    = pwrite_q;
      pwdata_d    = pwdata_q;
      psel_d      = psel_q;
      penable_d   = penable_q;
      rsp_valid_d = '0;
      rsp_rdata_d = '0;
      rsp_err_d   = 1'b0;
      ready_d     = '0;
      unique case (state_q)
         IDLE: begin
            if (gnt_any) begin
               ready_d  = gnt_oh;
               gidx_d   = gnt_idx;
               paddr_d  = {addr_sel[AW-1:2], 2'b00};
               pwrite_d = req_write_i[gnt_idx];
               pwdata_d = req_wdata_i[32'(gnt_idx)*32 +: 32];
               psel_d   = 1'b1;
               state_d  = SETUP;
            end
         end
         SETUP: begin
            penable_d = 1'b1;
            cnt_d     = '0;
            state_d   = ACCESS;
         end
         ACCESS: begin
            if (pready_i || tmo_hit) begin
               psel_d              = 1'b0;
               penable_d           = 1'b0;
               rsp_valid_d[gidx_q] = 1'b1;
               rsp_err_d           = pready_i ? pslverr_i : 1'b1;
               rsp_rdata_d         = (pready_i && !pwrite_q) ? prdata_i : 32'h0;
               rr_ptr_d            = (gidx_q == IW'(NREQ - 1)) ? '0 : gidx_q + IW'(1);
               state_d             = IDLE;
            end else if (cnt_q != '1) begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Gate the combinational accept so every output is 0 while reset is held.
   assign req_ready_o = hreset ? '0 : ready_d;
   assign rsp_valid_o = rsp_valid_q;
   assign rsp_rdata_o = rsp_rdata_q;
   assign rsp_err_o   = rsp_err_q;
   assign paddr_o     = paddr_q;
   assign psel_o      = psel_q;
   assign penable_o   = penable_q;
   assign pwrite_o    = pwrite_q;
   assign pwdata_o    = pwdata_q;
   assign busy_o      = (state_q != IDLE);

endmodule

// File: tb/tb_apb4_archinfo_arb.sv
// Self-checking bench: directed vector table, hand-written corner sequences, then random
// traffic against a transaction-level model of arbitration order, latency and responses.
module tb_apb4_archinfo_arb;

   localparam int NREQ    = 4;
   localparam int AW      = 6;
   localparam int TIMEOUT = 16;

   logic               hclk = 1'b0;
   logic               hreset = 1'b1;
   logic [NREQ-1:0]    req_valid_i, req_ready_o, req_write_i, rsp_valid_o;
   logic [NREQ*AW-1:0] req_addr_i;
   logic [NREQ*32-1:0] req_wdata_i;
   logic [31:0]        rsp_rdata_o, pwdata_o, prdata_i;
   logic               rsp_err_o, psel_o, penable_o, pwrite_o, pready_i, pslverr_i, busy_o;
   logic [AW-1:0]      paddr_o;

   int errors = 0;
   int checks = 0;

   apb4_archinfo_arb #(.NREQ(NREQ), .AW(AW), .TIMEOUT(TIMEOUT)) dut (
      .hclk        (hclk),
      .hreset      (hreset),
      .req_valid_i (req_valid_i),
      .req_ready_o (req_ready_o),
      .req_write_i (req_write_i),
      .req_addr_i  (req_addr_i),
      .req_wdata_i (req_wdata_i),
      .rsp_valid_o (rsp_valid_o),
      .rsp_rdata_o (rsp_rdata_o),
      .rsp_err_o   (rsp_err_o),
      .paddr_o     (paddr_o),
      .psel_o      (psel_o),
      .penable_o   (penable_o),
      .pwrite_o    (pwrite_o),
      .pwdata_o    (pwdata_o),
      .prdata_i    (prdata_i),
      .pready_i    (pready_i),
      .pslverr_i   (pslverr_i),
      .busy_o      (busy_o)
   );

   always #5 hclk = ~hclk;

   typedef struct {
      int            r;
      bit            wr;
      logic [AW-1:0] addr;
      logic [31:0]   wdata;
      logic [31:0]   prdata;
      int            waits;
      bit            slverr;
      logic [AW-1:0] e_paddr;
      logic [31:0]   e_rdata;
      bit            e_err;
      int            e_lat;
   } vec_t;

   vec_t tv[6];

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
      end
   endtask

   task automatic step();
      @(posedge hclk);
      #1;
   endtask

   task automatic set_cmd(input int r, input bit wr, input logic [AW-1:0] ad, input logic [31:0] wd);
      req_write_i[r]          = wr;
      req_addr_i[r*AW +: AW]  = ad;
      req_wdata_i[r*32 +: 32] = wd;
   endtask

   // Single isolated transfer; the bench slave raises pready after v.waits ACCESS cycles.
   task automatic run_vec(input vec_t v, input string tag);
      int lat;
      bit stable;
      bit seen;
      set_cmd(v.r, v.wr, v.addr, v.wdata);
      req_valid_i      = '0;
      req_valid_i[v.r] = 1'b1;
      prdata_i         = v.prdata;
      #1;
      chk({tag, "_ready"}, req_ready_o, 32'(1) << v.r);
      step();
      req_valid_i = '0;
      chk({tag, "_setup"}, {psel_o, penable_o}, 2'b10);
      lat = 1; stable = 1'b1; seen = 1'b0;
      while (!seen && lat < 40) begin
         step();
         lat++;
         pready_i  = (lat - 2 == v.waits);
         pslverr_i = pready_i & v.slverr;
         if (rsp_valid_o != '0) seen = 1'b1;
         else if (paddr_o !== v.e_paddr || pwrite_o !== v.wr || pwdata_o !== v.wdata ||
                  {psel_o, penable_o} !== 2'b11) stable = 1'b0;
      end
      pready_i  = 1'b0;
      pslverr_i = 1'b0;
      chk({tag, "_latency"}, lat, v.e_lat);
      chk({tag, "_stable"}, stable, 1);
      chk({tag, "_rsp_valid"}, rsp_valid_o, 32'(1) << v.r);
      chk({tag, "_rdata"}, rsp_rdata_o, v.e_rdata);
      chk({tag, "_err"}, rsp_err_o, v.e_err);
      chk({tag, "_psel_off"}, {psel_o, penable_o}, 2'b00);
      step();
      chk({tag, "_rsp_pulse"}, rsp_valid_o, 0);
   endtask

   initial begin
      #1_000_000;
      errors++;
      $display("FAIL watchdog: simulation time limit reached");
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $fatal(1, "time limit");
   end

   initial begin
      int            gq[$], gc[$], rq[$], rc[$];
      bit            bad;
      int            lat;
      // random-phase model state
      int            ptr, clr, k, end_c, g, a_r, a_t, a_w;
      bit            active, a_wr, a_err, in_rsp;
      logic [AW-1:0] a_addr, ad;
      logic [31:0]   a_wd, a_prd;
      logic [NREQ-1:0] exp_rdy;

      tv[0] = '{0, 1'b0, 6'h04, 32'h0,         32'hFFFF_FFFF, 0,  1'b0, 6'h04, 32'hFFFF_FFFF, 1'b0, 3};
      tv[1] = '{1, 1'b1, 6'h2C, 32'hA5A5_0001, 32'hDEAD_BEEF, 5,  1'b0, 6'h2C, 32'h0,         1'b0, 8};
      tv[2] = '{2, 1'b1, 6'h08, 32'h1234_5678, 32'h0,         0,  1'b1, 6'h08, 32'h0,         1'b1, 3};
      tv[3] = '{3, 1'b0, 6'h07, 32'h0,         32'h0BAD_F00D, 15, 1'b0, 6'h04, 32'h0BAD_F00D, 1'b0, 18};
      tv[4] = '{0, 1'b0, 6'h3F, 32'h0,         32'h1111_1111, 99, 1'b0, 6'h3C, 32'h0,         1'b1, 18};
      tv[5] = '{1, 1'b0, 6'h10, 32'h0,         32'hCAFE_0000, 2,  1'b1, 6'h10, 32'hCAFE_0000, 1'b1, 5};

      req_valid_i = '1;
      req_write_i = '0;
      req_addr_i  = '0;
      req_wdata_i = '0;
      prdata_i    = '0;
      pready_i    = 1'b0;
      pslverr_i   = 1'b0;

      // reset values, including accept suppressed while reset is held
      #12;
      chk("rst_ready", req_ready_o, 0);
      chk("rst_apb", {psel_o, penable_o, pwrite_o, busy_o}, 0);
      chk("rst_paddr", paddr_o, 0);
      chk("rst_pwdata", pwdata_o, 0);
      chk("rst_rsp", {rsp_valid_o, rsp_err_o}, 0);
      chk("rst_rdata", rsp_rdata_o, 0);
      req_valid_i = '0;
      step();
      hreset = 1'b0;

      for (int i = 0; i < 6; i++) run_vec(tv[i], $sformatf("vec%0d", i));

      // reset in the middle of ACCESS
      set_cmd(2, 1'b1, 6'h14, 32'h55AA_55AA);
      req_valid_i = 4'b0100;
      #1;
      chk("rstacc_ready", req_ready_o, 4'b0100);
      step();
      req_valid_i = '0;
      step();
      step();
      chk("rstacc_in_access", {psel_o, penable_o}, 2'b11);
      #2 hreset = 1'b1;
      #1;
      chk("rstacc_apb_drop", {psel_o, penable_o, busy_o}, 0);
      for (int i = 0; i < NREQ; i++) set_cmd(i, 1'b0, AW'(4 * i), 32'h0);
      req_valid_i = '1;
      pready_i    = 1'b1;
      bad         = 1'b0;
      repeat (3) begin
         step();
         if (rsp_valid_o != '0 || req_ready_o != '0) bad = 1'b1;
      end
      chk("rstacc_quiet", bad, 0);
      hreset = 1'b0;
      #1;
      chk("rstacc_first_grant", req_ready_o, 4'b0001);

      // contention: all requesters valid, zero wait states
      bad = 1'b0;
      for (int c = 0; c < 16; c++) begin
         if ($countones(req_ready_o) > 1 || $countones(rsp_valid_o) > 1) bad = 1'b1;
         for (int i = 0; i < NREQ; i++) begin
            if (req_ready_o[i]) begin gq.push_back(i); gc.push_back(c); end
            if (rsp_valid_o[i]) begin rq.push_back(i); rc.push_back(c); end
         end
         step();
      end
      chk("cont_onehot", bad, 0);
      chk("cont_ngrants", gq.size(), 6);
      chk("cont_nrsp", rq.size(), 5);
      if (gq.size() >= 5 && rq.size() >= 5) begin
         for (int n = 0; n < 5; n++) begin
            chk($sformatf("cont_grant%0d", n), gq[n], n % NREQ);
            chk($sformatf("cont_gcyc%0d", n), gc[n], 3 * n);
            chk($sformatf("cont_rsp%0d", n), rq[n], n % NREQ);
            chk($sformatf("cont_rcyc%0d", n), rc[n], 3 * n + 3);
         end
      end
      req_valid_i = '0;
      lat = 0;
      while (busy_o && lat < 40) begin step(); lat++; end
      step();
      pready_i = 1'b0;

      // watchdog expiry, then a requester that arrived mid-transfer is served
      set_cmd(1, 1'b0, 6'h20, 32'h0);
      req_valid_i = 4'b0010;
      #1;
      chk("tmo_ready", req_ready_o, 4'b0010);
      step();
      req_valid_i = '0;
      step();
      set_cmd(3, 1'b0, 6'h24, 32'h0);
      req_valid_i = 4'b1000;
      prdata_i    = 32'h77;
      lat = 2;
      bad = 1'b0;
      while (rsp_valid_o == '0 && lat < 40) begin
         if (req_ready_o != '0) bad = 1'b1;
         step();
         lat++;
      end
      chk("tmo_no_early_grant", bad, 0);
      chk("tmo_latency", lat, 18);
      chk("tmo_rsp_valid", rsp_valid_o, 4'b0010);
      chk("tmo_err", rsp_err_o, 1);
      chk("tmo_rdata", rsp_rdata_o, 0);
      chk("tmo_psel", {psel_o, penable_o}, 2'b00);
      chk("tmo_next_grant", req_ready_o, 4'b1000);
      step();
      req_valid_i = '0;
      pready_i    = 1'b1;
      step();
      step();
      chk("tmo_next_rsp", rsp_valid_o, 4'b1000);
      chk("tmo_next_rdata", rsp_rdata_o, 32'h77);
      chk("tmo_next_err", rsp_err_o, 0);
      pready_i = 1'b0;
      step();

      // random traffic against a transaction-level model
      hreset = 1'b1;
      step();
      hreset = 1'b0;
      ptr = 0; clr = -1; active = 1'b0;
      a_r = 0; a_t = 0; a_w = 0; a_wr = 0; a_err = 0; a_addr = '0; a_wd = '0; a_prd = '0;
      for (int c = 0; c < 1500; c++) begin
         if (clr >= 0) begin req_valid_i[clr] = 1'b0; clr = -1; end
         for (int i = 0; i < NREQ; i++) begin
            if (!req_valid_i[i]) begin
               if ($urandom_range(0, 3) == 0) begin
                  set_cmd(i, 1'($urandom_range(0, 1)), AW'($urandom), $urandom);
                  req_valid_i[i] = 1'b1;
               end
            end else if ($urandom_range(0, 19) == 0) begin
               req_valid_i[i] = 1'b0;
            end
         end
         k = c - a_t - 2;
         if (active && k >= 0) begin
            pready_i  = (k == a_w);
            pslverr_i = a_err;
            prdata_i  = a_prd;
         end else begin
            pready_i  = 1'($urandom_range(0, 1));
            pslverr_i = 1'($urandom_range(0, 1));
            prdata_i  = $urandom;
         end
         #1;
         end_c  = a_t + 3 + ((a_w > 15) ? 15 : a_w);
         in_rsp = active && (c == end_c);
         if (in_rsp) begin
            chk("rnd_rsp_valid", rsp_valid_o, 32'(1) << a_r);
            chk("rnd_rdata", rsp_rdata_o, (a_w > 15 || a_wr) ? 32'h0 : a_prd);
            chk("rnd_err", rsp_err_o, (a_w > 15) ? 1'b1 : a_err);
         end else begin
            chk("rnd_rsp_idle", rsp_valid_o, 0);
         end
         if (active && c == a_t + 1) chk("rnd_setup", {psel_o, penable_o, busy_o}, 3'b101);
         else if (active && c > a_t + 1 && c < end_c) chk("rnd_access", {psel_o, penable_o, busy_o}, 3'b111);
         else chk("rnd_rest", {psel_o, penable_o, busy_o}, 3'b000);
         if (active && c > a_t && c <= end_c) begin
            chk("rnd_paddr", paddr_o, a_addr);
            chk("rnd_pwrite", pwrite_o, a_wr);
            chk("rnd_pwdata", pwdata_o, a_wd);
         end
         exp_rdy = '0;
         g = -1;
         if ((!active || c >= end_c) && req_valid_i != '0) begin
            for (int n = 0; n < NREQ; n++) begin
               if (g < 0 && req_valid_i[(ptr + n) % NREQ]) g = (ptr + n) % NREQ;
            end
            exp_rdy[g] = 1'b1;
         end
         chk("rnd_ready", req_ready_o, exp_rdy);
         if (g >= 0) begin
            ad     = req_addr_i[g*AW +: AW];
            active = 1'b1;
            a_r    = g;
            a_t    = c;
            a_w    = $urandom_range(0, 20);
            a_wr   = req_write_i[g];
            a_addr = {ad[AW-1:2], 2'b00};
            a_wd   = req_wdata_i[g*32 +: 32];
            a_prd  = $urandom;
            a_err  = ($urandom_range(0, 3) == 0);
            ptr    = (g + 1) % NREQ;
            clr    = g;
         end else if (in_rsp) begin
            active = 1'b0;
         end
         step();
      end
      req_valid_i = '0;
      pready_i    = 1'b1;
      lat = 0;
      while (busy_o && lat < 40) begin step(); lat++; end
      chk("rnd_drain", busy_o, 0);
      step();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
